// File: rtl/key_event_pkg.sv
// Shared definitions for the key event sequencer: state encoding and the
// microsecond-to-cycle conversion used to size its timers.
package key_event_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StWait2  = 3'd2,
    StPress2 = 3'd3,
    StLong   = 3'd4
  } state_e;

  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_cyc);
    longint unsigned ns;
    ns = 64'(us) * 64'd1000;
    return 32'(ns / 64'(clk_cyc));
  endfunction

endpackage

// File: rtl/key_evt_timer.sv
// Clearable free-running up-counter; tc is a combinational compare of the
// current count against a terminal value chosen by the owner.
module key_evt_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [Width-1:0] term_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + Width'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/key_event_ctrl.sv
// Turns a debounced active-low key into single, double, long-press and
// auto-repeat event pulses, each one cycle wide and registered.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned CLK_CYC = 10,
  parameter int unsigned LONG_US = 1000000,
  parameter int unsigned DBL_US  = 300000,
  parameter int unsigned RPT_US  = 200000
) (
  input  logic sysclk,
  input  logic rst,
  input  logic en,
  input  logic key_in,
  output logic single_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int unsigned LONG_CNT = us_to_cyc(LONG_US, CLK_CYC);
  localparam int unsigned DBL_CNT  = us_to_cyc(DBL_US, CLK_CYC);
  localparam int unsigned RPT_CNT  = us_to_cyc(RPT_US, CLK_CYC);
  localparam int unsigned MAX_LD   = (LONG_CNT > DBL_CNT) ? LONG_CNT : DBL_CNT;
  localparam int unsigned MAX_CNT  = (MAX_LD > RPT_CNT) ? MAX_LD : RPT_CNT;
  localparam int unsigned CntW     = $clog2(MAX_CNT);

  if (LONG_CNT < 2 || DBL_CNT < 2 || RPT_CNT < 2) begin : g_bad_cnt
    $error("key_event_ctrl: every derived cycle count must be at least 2");
  end

  state_e          state_q, state_d;
  logic            key_r, armed_q;
  logic            fall, rise;
  logic            single_d, double_d, long_d, repeat_d;
  logic            rpt_wrap, cnt_clr, tc;
  logic [CntW-1:0] term;

  // key_r is forced high by reset, so a key held through reset would look like
  // a fresh press; armed_q holds off falls until a released key has been seen.
  assign fall = key_r & ~key_in & armed_q;
  assign rise = ~key_r & key_in;

  always_comb begin
    term = '1;
    case (state_q)
      StPress1: term = CntW'(LONG_CNT - 1);
      StWait2:  term = CntW'(DBL_CNT - 1);
      StLong:   term = CntW'(RPT_CNT - 1);
      default:  term = '1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    rpt_wrap = 1'b0;
    // Key edges are tested before the timer so an edge wins on a terminal cycle.
    case (state_q)
      StIdle: begin
        if (fall) state_d = StPress1;
      end
      StPress1: begin
        if (rise) begin
          state_d = StWait2;
        end else if (tc) begin
          state_d = StLong;
          long_d  = 1'b1;
        end
      end
      StWait2: begin
        if (fall) begin
          state_d = StPress2;
        end else if (tc) begin
          state_d  = StIdle;
          single_d = 1'b1;
        end
      end
      StPress2: begin
        if (rise) begin
          state_d  = StIdle;
          double_d = 1'b1;
        end
      end
      StLong: begin
        if (rise) begin
          state_d = StIdle;
        end else if (tc) begin
          repeat_d = 1'b1;
          rpt_wrap = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en) begin
      state_d  = StIdle;
      single_d = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      rpt_wrap = 1'b0;
    end
  end

  // Holding the count at zero while idle keeps it quiet between sequences.
  assign cnt_clr = (state_d != state_q) | rpt_wrap | (state_q == StIdle);

  key_evt_timer #(
    .Width(CntW)
  ) u_timer (
    .clk_i (sysclk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .term_i(term),
    .tc_o  (tc)
  );

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q      <= StIdle;
      key_r        <= 1'b1;
      armed_q      <= 1'b0;
      single_pulse <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_r        <= key_in;
      armed_q      <= armed_q | key_in;
      single_pulse <= single_d;
      double_pulse <= double_d;
      long_pulse   <= long_d;
      repeat_pulse <= repeat_d;
      busy         <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random key traffic, every
// cycle compared against a timestamp-based event model.
module tb_key_event_ctrl;

  localparam int unsigned CLK_CYC = 10;
  localparam int unsigned LONG_US = 20;
  localparam int unsigned DBL_US  = 5;
  localparam int unsigned RPT_US  = 4;
  localparam int LONG_CNT = LONG_US * 1000 / CLK_CYC;
  localparam int DBL_CNT  = DBL_US * 1000 / CLK_CYC;
  localparam int RPT_CNT  = RPT_US * 1000 / CLK_CYC;

  localparam int P_NONE  = 0;
  localparam int P_HELD  = 1;
  localparam int P_GAP   = 2;
  localparam int P_HELD2 = 3;
  localparam int P_LONG  = 4;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  logic en     = 1'b1;
  logic key_in = 1'b1;
  logic single_pulse, double_pulse, long_pulse, repeat_pulse, busy;

  always #5 sysclk = ~sysclk;

  key_event_ctrl #(
    .CLK_CYC(CLK_CYC),
    .LONG_US(LONG_US),
    .DBL_US (DBL_US),
    .RPT_US (RPT_US)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .en          (en),
    .key_in      (key_in),
    .single_pulse(single_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;  // index of the edge the next tick() waits for
  int s0     = 0;

  // Reference model: an abstract phase plus the edge index at which it began.
  int         phase  = P_NONE;
  int         t_mark = 0;
  bit         m_prev = 1'b1;
  bit         m_armed = 1'b0;
  logic [4:0] exp_v;

  int n_single, n_double, n_long, n_repeat;
  int at_single, at_double, at_long, at_repeat, first_repeat;

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic s, d, l, r;
    bit   fall, rise;
    s = 1'b0; d = 1'b0; l = 1'b0; r = 1'b0;
    if (rst) begin
      phase   = P_NONE;
      m_prev  = 1'b1;
      m_armed = 1'b0;
    end else begin
      fall = m_prev && !key_in && m_armed;
      rise = !m_prev && key_in;
      if (!en) begin
        phase = P_NONE;
      end else begin
        case (phase)
          P_NONE: if (fall) begin phase = P_HELD; t_mark = cyc; end
          P_HELD: begin
            if (rise) begin
              phase = P_GAP; t_mark = cyc;
            end else if (cyc - t_mark == LONG_CNT) begin
              l = 1'b1; phase = P_LONG; t_mark = cyc;
            end
          end
          P_GAP: begin
            if (fall) phase = P_HELD2;
            else if (cyc - t_mark == DBL_CNT) begin s = 1'b1; phase = P_NONE; end
          end
          P_HELD2: if (rise) begin d = 1'b1; phase = P_NONE; end
          default: begin
            if (rise) phase = P_NONE;
            else if ((cyc - t_mark) % RPT_CNT == 0) r = 1'b1;
          end
        endcase
      end
      m_prev = key_in;
      if (key_in) m_armed = 1'b1;
    end
    exp_v = {s, d, l, r, phase != P_NONE};
  endtask

  task automatic tick();
    logic [4:0] obs;
    @(posedge sysclk);
    model_step();
    #1;
    obs = {single_pulse, double_pulse, long_pulse, repeat_pulse, busy};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL outputs@%0d: observed %b, expected %b (s,d,l,r,busy)", cyc, obs, exp_v);
    end
    checks++;
    assert ($countones(obs[4:1]) <= 1) else begin
      errors++;
      $error("FAIL onehot@%0d: observed %b, expected at most one pulse", cyc, obs[4:1]);
    end
    if (single_pulse) begin n_single++; at_single = cyc - s0; end
    if (double_pulse) begin n_double++; at_double = cyc - s0; end
    if (long_pulse)   begin n_long++;   at_long   = cyc - s0; end
    if (repeat_pulse) begin
      if (n_repeat == 0) first_repeat = cyc - s0;
      n_repeat++; at_repeat = cyc - s0;
    end
    cyc++;
  endtask

  task automatic hold(input logic k, input int n);
    key_in = k;
    repeat (n) tick();
  endtask

  // Marks the next edge as n=0 and clears the per-scenario pulse log.
  task automatic start();
    s0 = cyc;
    n_single = 0; n_double = 0; n_long = 0; n_repeat = 0;
    at_single = -1; at_double = -1; at_long = -1; at_repeat = -1; first_repeat = -1;
  endtask

  initial begin
    int p1, gap, p2;
    start();
    rst = 1'b1;
    repeat (3) tick();
    check_int("reset_outputs",
              int'({single_pulse, double_pulse, long_pulse, repeat_pulse, busy}), 0);
    rst = 1'b0;
    hold(1'b1, 5);

    // Single click.
    start(); hold(1'b0, 100); hold(1'b1, 700);
    check_int("single_count", n_single, 1);
    check_int("single_time", at_single, 100 + DBL_CNT);
    check_int("single_no_double", n_double, 0);
    check_int("single_no_long", n_long + n_repeat, 0);

    // Double click.
    start(); hold(1'b0, 100); hold(1'b1, 200); hold(1'b0, 100); hold(1'b1, 700);
    check_int("double_count", n_double, 1);
    check_int("double_time", at_double, 400);
    check_int("double_no_single", n_single, 0);

    // Long press with auto-repeat.
    start(); hold(1'b0, 3000); hold(1'b1, 1);
    check_int("long_release_busy", int'(busy), 0);
    hold(1'b1, 699);
    check_int("long_count", n_long, 1);
    check_int("long_time", at_long, LONG_CNT);
    check_int("repeat_count", n_repeat, 2);
    check_int("repeat_first", first_repeat, LONG_CNT + RPT_CNT);
    check_int("repeat_last", at_repeat, LONG_CNT + 2 * RPT_CNT);
    check_int("long_no_click", n_single + n_double, 0);

    // Release one edge before, and exactly on, the long-press terminal edge.
    start(); hold(1'b0, LONG_CNT - 1); hold(1'b1, 800);
    check_int("bnd_early_no_long", n_long, 0);
    check_int("bnd_early_single", at_single, LONG_CNT - 1 + DBL_CNT);
    start(); hold(1'b0, LONG_CNT); hold(1'b1, 800);
    check_int("bnd_term_no_long", n_long, 0);
    check_int("bnd_term_single", at_single, LONG_CNT + DBL_CNT);

    // Second press on the double-click terminal edge.
    start(); hold(1'b0, 100); hold(1'b1, DBL_CNT); hold(1'b0, 50); hold(1'b1, 700);
    check_int("bnd_dbl_no_single", n_single, 0);
    check_int("bnd_dbl_double", at_double, 100 + DBL_CNT + 50);

    // Reset mid-hold, key still held afterwards.
    start(); hold(1'b0, 1500);
    rst = 1'b1; tick(); rst = 1'b0;
    check_int("rst_busy", int'(busy), 0);
    hold(1'b0, 1499); hold(1'b1, 700);
    check_int("rst_no_pulses", n_single + n_double + n_long + n_repeat, 0);
    start(); hold(1'b0, 100); hold(1'b1, 700);
    check_int("rst_then_single", at_single, 100 + DBL_CNT);

    // Enable dropped in the gap, then raised while the key is held.
    start(); hold(1'b0, 100); hold(1'b1, 200);
    en = 1'b0; tick();
    check_int("en_busy", int'(busy), 0);
    hold(1'b1, 500); hold(1'b0, 50);
    en = 1'b1; hold(1'b0, 2500);
    check_int("en_no_pulses", n_single + n_double + n_long + n_repeat, 0);
    hold(1'b1, 100);
    start(); hold(1'b0, 100); hold(1'b1, 700);
    check_int("en_then_single", at_single, 100 + DBL_CNT);

    // Random traffic; timing picks cluster around the terminal counts.
    for (int ep = 0; ep < 10; ep++) begin
      start();
      case ($urandom_range(0, 3))
        0:       p1 = LONG_CNT - 1 + int'($urandom_range(0, 2));
        1:       p1 = int'($urandom_range(1, 60));
        default: p1 = int'($urandom_range(1, 2600));
      endcase
      gap = ($urandom_range(0, 1) == 1) ? DBL_CNT - 1 + int'($urandom_range(0, 2))
                                        : int'($urandom_range(1, 650));
      p2  = int'($urandom_range(1, 300));
      en = ($urandom_range(0, 7) != 0);
      hold(1'b0, p1);
      en = ($urandom_range(0, 7) != 0);
      hold(1'b1, gap);
      if ($urandom_range(0, 1) == 1) begin
        rst = ($urandom_range(0, 9) == 0);
        hold(1'b0, 1);
        rst = 1'b0;
        hold(1'b0, p2);
      end
      en = 1'b1;
      hold(1'b1, 600);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
